// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMRD    = 4'd3,
      MEMWB    = 4'd4,
      MEMWR    = 4'd5,
      EXECUTE  = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
      ADDIEXEC = 4'd9,
      ADDIWB   = 4'd10,
      JUMP     = 4'd11,
      BNE      = 4'd12
   } statetype;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_dec.sv
// ALU decoder: maps the FSM's aluop and the R-type funct field to an ALU operation.
module alu_dec
   import mips_ctrl_pkg::*;
(
   input  aluop_t      aluop,
   input  logic [5:0]  funct,
   output logic [2:0]  alucontrol
);

   always_comb begin
      alucontrol = ALU_ADD;
      case (aluop)
         ALUOP_SUB:   alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            case (funct)
               F_ADD:   alucontrol = ALU_ADD;
               F_SUB:   alucontrol = ALU_SUB;
               F_AND:   alucontrol = ALU_AND;
               F_OR:    alucontrol = ALU_OR;
               F_SLT:   alucontrol = ALU_SLT;
               default: alucontrol = ALU_ADD;
            endcase
         end
         default:     alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch/decode/execute,
// driving datapath selects and write enables, plus the ALU decoder.
module mc_main_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter bit SUPPORT_BNE = 1'b1
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  op,
   input  logic [5:0]  funct,
   input  logic        zero,
   output logic        memwrite,
   output logic        lord,
   output logic        irwrite,
   output logic        regdst,
   output logic        memtoreg,
   output logic        regwrite,
   output logic        alusrca,
   output logic [1:0]  alusrcb,
   output logic [1:0]  pcsrc,
   output logic [2:0]  alucontrol,
   output logic        pcen,
   output logic [3:0]  state,
   output logic        illegal
);

   statetype state_q, state_d, dstate;
   aluop_t   aluop;
   logic     pcwrite, branch, bnebr;
   logic     mw_raw, ir_raw, rw_raw, ill_raw;

   always_ff @(posedge clk) begin
      if (!reset) state_q <= FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = FETCH;
      ill_raw = 1'b0;
      case (state_q)
         FETCH:    state_d = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW: state_d = MEMADR;
               OP_RTYPE:     state_d = EXECUTE;
               OP_BEQ:       state_d = BRANCH;
               OP_BNE: begin
                  state_d = SUPPORT_BNE ? BNE : FETCH;
                  ill_raw = !SUPPORT_BNE;
               end
               OP_ADDI:      state_d = ADDIEXEC;
               OP_J:         state_d = JUMP;
               default: begin
                  state_d = FETCH;
                  ill_raw = 1'b1;
               end
            endcase
         end
         MEMADR:   state_d = (op == OP_LW) ? MEMRD : MEMWR;
         MEMRD:    state_d = MEMWB;
         EXECUTE:  state_d = ALUWB;
         ADDIEXEC: state_d = ADDIWB;
         default:  state_d = FETCH;
      endcase
   end

   // While reset is held the datapath sees FETCH selects; enables are gated below.
   assign dstate = reset ? state_q : FETCH;

   always_comb begin
      mw_raw   = 1'b0;
      ir_raw   = 1'b0;
      rw_raw   = 1'b0;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      bnebr    = 1'b0;
      lord     = 1'b0;
      regdst   = 1'b0;
      memtoreg = 1'b0;
      alusrca  = 1'b0;
      alusrcb  = 2'b00;
      pcsrc    = 2'b00;
      aluop    = ALUOP_ADD;
      case (dstate)
         FETCH: begin
            ir_raw  = 1'b1;
            pcwrite = 1'b1;
            alusrcb = 2'b01;
         end
         DECODE:   alusrcb = 2'b11;
         MEMADR, ADDIEXEC: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
         end
         MEMRD:    lord = 1'b1;
         MEMWB: begin
            rw_raw   = 1'b1;
            memtoreg = 1'b1;
         end
         MEMWR: begin
            lord   = 1'b1;
            mw_raw = 1'b1;
         end
         EXECUTE: begin
            alusrca = 1'b1;
            aluop   = ALUOP_FUNCT;
         end
         ALUWB: begin
            regdst = 1'b1;
            rw_raw = 1'b1;
         end
         ADDIWB:   rw_raw = 1'b1;
         BRANCH, BNE: begin
            alusrca = 1'b1;
            pcsrc   = 2'b01;
            aluop   = ALUOP_SUB;
            branch  = (dstate == BRANCH);
            bnebr   = (dstate == BNE);
         end
         JUMP: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
         default:  alusrcb = 2'b01;
      endcase
   end

   assign memwrite = reset & mw_raw;
   assign irwrite  = reset & ir_raw;
   assign regwrite = reset & rw_raw;
   assign illegal  = reset & ill_raw;
   assign pcen     = reset & (pcwrite | (branch & zero) | (bnebr & ~zero));
   assign state    = state_q;

   alu_dec u_alu_dec (
      .aluop      (aluop),
      .funct      (funct),
      .alucontrol (alucontrol)
   );

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Randomized bench for mc_main_ctrl against an instruction/step reference model.
module tb_mc_main_ctrl;

   typedef struct packed {
      logic [3:0] st;
      logic       memwrite, lord, irwrite, regdst, memtoreg, regwrite, alusrca;
      logic [1:0] alusrcb, pcsrc;
      logic [2:0] alucontrol;
      logic       pcen, illegal;
   } exp_t;

   typedef enum int {K_LW, K_SW, K_R, K_BEQ, K_BNE, K_ADDI, K_J, K_ILL} kind_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op, funct;
   logic       zero;

   logic       memwrite0, lord0, irwrite0, regdst0, memtoreg0, regwrite0, alusrca0, pcen0, illegal0;
   logic [1:0] alusrcb0, pcsrc0;
   logic [2:0] alucontrol0;
   logic [3:0] state0;
   logic       memwrite1, lord1, irwrite1, regdst1, memtoreg1, regwrite1, alusrca1, pcen1, illegal1;
   logic [1:0] alusrcb1, pcsrc1;
   logic [2:0] alucontrol1;
   logic [3:0] state1;
   exp_t       got0, got1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mc_main_ctrl #(.SUPPORT_BNE(1'b1)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .memwrite(memwrite0), .lord(lord0), .irwrite(irwrite0), .regdst(regdst0),
      .memtoreg(memtoreg0), .regwrite(regwrite0), .alusrca(alusrca0), .alusrcb(alusrcb0),
      .pcsrc(pcsrc0), .alucontrol(alucontrol0), .pcen(pcen0), .state(state0), .illegal(illegal0)
   );

   mc_main_ctrl #(.SUPPORT_BNE(1'b0)) dut_nb (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .memwrite(memwrite1), .lord(lord1), .irwrite(irwrite1), .regdst(regdst1),
      .memtoreg(memtoreg1), .regwrite(regwrite1), .alusrca(alusrca1), .alusrcb(alusrcb1),
      .pcsrc(pcsrc1), .alucontrol(alucontrol1), .pcen(pcen1), .state(state1), .illegal(illegal1)
   );

   assign got0 = {state0, memwrite0, lord0, irwrite0, regdst0, memtoreg0, regwrite0, alusrca0,
                  alusrcb0, pcsrc0, alucontrol0, pcen0, illegal0};
   assign got1 = {state1, memwrite1, lord1, irwrite1, regdst1, memtoreg1, regwrite1, alusrca1,
                  alusrcb1, pcsrc1, alucontrol1, pcen1, illegal1};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic kind_t kind_of(input logic [5:0] o, input bit bne_ok);
      case (o)
         6'b100011: return K_LW;
         6'b101011: return K_SW;
         6'b000000: return K_R;
         6'b000100: return K_BEQ;
         6'b000101: return bne_ok ? K_BNE : K_ILL;
         6'b001000: return K_ADDI;
         6'b000010: return K_J;
         default:   return K_ILL;
      endcase
   endfunction

   function automatic int n_steps(input kind_t k);
      case (k)
         K_LW:               return 5;
         K_SW, K_R, K_ADDI:  return 4;
         K_BEQ, K_BNE, K_J:  return 3;
         default:            return 2;
      endcase
   endfunction

   function automatic logic [2:0] funct_alu(input logic [5:0] f);
      case (f)
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   // Outputs seen while reset is low: FETCH selects, no enables.
   function automatic exp_t rst_exp(input logic [3:0] st);
      exp_t e = '0;
      e.st = st; e.alusrcb = 2'b01; e.alucontrol = 3'b010;
      return e;
   endfunction

   function automatic exp_t step_exp(input kind_t k, input int s, input logic [5:0] f, input logic z);
      exp_t e = '0;
      e.alucontrol = 3'b010;
      if (s == 0) begin
         e.st = 4'd0; e.irwrite = 1; e.pcen = 1; e.alusrcb = 2'b01;
      end else if (s == 1) begin
         e.st = 4'd1; e.alusrcb = 2'b11; e.illegal = (k == K_ILL);
      end else begin
         case (k)
            K_LW, K_SW, K_ADDI:
               if (s == 2) begin
                  e.st = (k == K_ADDI) ? 4'd9 : 4'd2; e.alusrca = 1; e.alusrcb = 2'b10;
               end else if (k == K_LW && s == 3) begin
                  e.st = 4'd3; e.lord = 1;
               end else if (k == K_LW) begin
                  e.st = 4'd4; e.regwrite = 1; e.memtoreg = 1;
               end else if (k == K_SW) begin
                  e.st = 4'd5; e.lord = 1; e.memwrite = 1;
               end else begin
                  e.st = 4'd10; e.regwrite = 1;
               end
            K_R:
               if (s == 2) begin
                  e.st = 4'd6; e.alusrca = 1; e.alucontrol = funct_alu(f);
               end else begin
                  e.st = 4'd7; e.regdst = 1; e.regwrite = 1;
               end
            K_BEQ, K_BNE: begin
               e.st = (k == K_BEQ) ? 4'd8 : 4'd12; e.alusrca = 1; e.pcsrc = 2'b01;
               e.alucontrol = 3'b110; e.pcen = (k == K_BEQ) ? z : ~z;
            end
            K_J: begin
               e.st = 4'd11; e.pcsrc = 2'b10; e.pcen = 1;
            end
            default: e = '0;
         endcase
      end
      return e;
   endfunction

   // ---------------- stimulus ----------------
   task automatic do_reset(input int n, input logic [3:0] first_st);
      reset = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk($sformatf("rst%0d", i), got0, rst_exp(i == 0 ? first_st : 4'd0));
         @(posedge clk); #1;
      end
      reset = 1'b1;
   endtask

   // zmode: 0/1 force zero, 2 random per cycle; nmax limits steps (0 = full instruction)
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode, input int nmax);
      kind_t k = kind_of(o, 1'b1);
      int    n = n_steps(k);
      if (nmax > 0 && nmax < n) n = nmax;
      op = o; funct = f;
      for (int s = 0; s < n; s++) begin
         zero = (zmode == 2) ? 1'($urandom_range(1)) : zmode[0];
         @(negedge clk);
         chk($sformatf("op%02h.s%0d", o, s), got0, step_exp(k, s, f, zero));
         @(posedge clk); #1;
      end
   endtask

   function automatic logic [5:0] rand_funct();
      logic [5:0] tbl [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      int idx = $urandom_range(5);
      return (idx == 5) ? 6'($urandom) : tbl[idx];
   endfunction

   function automatic logic [5:0] rand_op();
      logic [5:0] tbl [7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000101, 6'b001000, 6'b000010};
      logic [5:0] o;
      int idx = $urandom_range(7);
      if (idx < 7) return tbl[idx];
      do o = 6'($urandom); while (kind_of(o, 1'b1) != K_ILL);
      return o;
   endfunction

   initial begin
      reset = 1'b0; op = '0; funct = '0; zero = 1'b0;
      do_reset(2, 4'd0);

      // bne on both variants: the unsupported one flags illegal and refetches
      op = 6'b000101; funct = '0;
      for (int s = 0; s < 3; s++) begin
         zero = 1'b0;
         @(negedge clk);
         chk($sformatf("bne.s%0d", s), got0, step_exp(K_BNE, s, funct, zero));
         if (s < 2) chk($sformatf("nobne.s%0d", s), got1, step_exp(K_ILL, s, funct, zero));
         else       chk("nobne.refetch", {28'd0, state1}, 32'd0);
         @(posedge clk); #1;
      end
      do_reset(1, 4'd0);

      run_instr(6'b100011, 6'b000000, 2, 0);
      run_instr(6'b101011, 6'b000000, 2, 0);
      run_instr(6'b000000, 6'b100010, 2, 0);
      run_instr(6'b000000, 6'b101010, 2, 0);
      run_instr(6'b000100, 6'b000000, 1, 0);
      run_instr(6'b000100, 6'b000000, 0, 0);
      run_instr(6'b000101, 6'b000000, 0, 0);
      run_instr(6'b000101, 6'b000000, 1, 0);
      run_instr(6'b001000, 6'b000000, 2, 0);
      run_instr(6'b000010, 6'b000000, 2, 0);
      run_instr(6'b111111, 6'b000000, 2, 0);

      // abort lw in MEMRD: no write-back must follow
      run_instr(6'b100011, 6'b000000, 2, 3);
      do_reset(2, 4'd3);

      for (int i = 0; i < 60; i++) run_instr(rand_op(), rand_funct(), 2, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
